// File: rtl/ysyx_24080006_pkg.sv
// Shared pipeline types for the ysyx_24080006 core: per-stage payload bundles
// carried through ysyx_24080006_stage_buf, plus the limits of that buffer.
package ysyx_24080006_pkg;

    localparam int XLEN          = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int CSR_ADDR_W    = 12;
    localparam int BUF_DEPTH_MIN = 1;
    localparam int BUF_DEPTH_MAX = 16;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_a_sel_e;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    typedef struct packed {
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       branch;
        logic       jump;
        logic       ecall;
        logic       mret;
        logic       ebreak;
        wb_sel_e    wb_sel;
        alu_a_sel_e alu_a_sel;
        logic       alu_b_imm;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [CSR_ADDR_W-1:0] csr_addr;
        csr_op_e               csr_op;
        logic [2:0]            funct3;
        alu_op_e               alu_op;
        ctrl_t                 ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       dnpc;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       sdata;
        logic [XLEN-1:0]       csr_wdata;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [CSR_ADDR_W-1:0] csr_addr;
        csr_op_e               csr_op;
        logic [2:0]            funct3;
        ctrl_t                 ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       dnpc;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       mem_rdata;
        logic [XLEN-1:0]       csr_rdata;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [2:0]            funct3;
        ctrl_t                 ctrl;
    } mem_wb_t;

    // Buffer WIDTH values for each pipeline boundary.
    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    function automatic logic depth_legal(input int depth);
        return (depth >= BUF_DEPTH_MIN) && (depth <= BUF_DEPTH_MAX);
    endfunction

endpackage

// File: rtl/ysyx_24080006_stage_buf.sv
// Valid/ready pipeline stage buffer: small circular FIFO with optional
// combinational fall-through when empty. Flush and reset drop all entries.
module ysyx_24080006_stage_buf
    import ysyx_24080006_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PASS  = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $fatal(1, "ysyx_24080006_stage_buf: DEPTH=%0d outside %0d..%0d",
               DEPTH, BUF_DEPTH_MIN, BUF_DEPTH_MAX);
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (cnt == '0);
    assign full   = (cnt == FULL_CNT);
    assign bypass = (PASS != 0) && empty;

    assign in_ready  = !full && !flush;
    assign out_valid = !flush && (!empty || (bypass && in_valid));
    assign out_data  = bypass ? in_data : mem[rd_ptr];
    assign count     = cnt;

    // A fall-through transfer leaves storage untouched.
    assign push = in_valid && in_ready && !(bypass && out_ready);
    assign pop  = out_valid && out_ready && !empty;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; entries are only meaningful below cnt.
    always_ff @(posedge clock) begin
        if (push && !reset) mem[wr_ptr] <= in_data;
    end

endmodule

// File: doc/ysyx_24080006_stage_buf.md
YSYX_24080006_STAGE_BUF -- requirements
Module: ysyx_24080006_stage_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload bits per entry.
REQ-002 SHALL have parameter DEPTH, default 2, legal range 1..16: number of storage entries.
REQ-003 SHALL have parameter PASS, default 0: 1 = fall-through when empty, 0 = fully registered.
REQ-004 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1: discard all held entries (pipeline redirect).
REQ-007 SHALL have port in_valid, input, 1: upstream stage offers in_data.
REQ-008 SHALL have port in_ready, output, 1: buffer accepts in_data this cycle.
REQ-009 SHALL have port in_data, input, WIDTH: upstream payload.
REQ-010 SHALL have port out_valid, output, 1: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1: downstream stage accepts out_data.
REQ-012 SHALL have port out_data, output, WIDTH: oldest payload.
REQ-013 SHALL have port count, output, $clog2(DEPTH+1): number of held entries.

Function
REQ-014 SHALL push on in_valid && in_ready and pop on out_valid && out_ready, both at the rising clock edge.
REQ-015 SHALL drive in_ready = (count < DEPTH) && !flush; it SHALL NOT depend combinationally on out_ready.
REQ-016 SHALL drive out_valid = (count != 0) && !flush when PASS=0.
REQ-017 SHALL, when PASS=1 and count==0, drive out_valid = in_valid && !flush and out_data = in_data combinationally; on a same-cycle pop nothing is written and count stays 0.
REQ-018 SHALL store entries in a circular buffer using write and read pointers that wrap from DEPTH-1 to 0; non-power-of-two DEPTH SHALL wrap correctly.
REQ-019 SHALL support simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-020 SHALL deliver out_data in strict FIFO order with no loss or duplication.
REQ-021 SHALL sustain one transfer per cycle in steady state when DEPTH >= 2, or when DEPTH = 1 with PASS=1.
REQ-022 SHALL drive out_data from the read-pointer entry when count != 0; out_data is don't-care when out_valid=0.
REQ-023 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on flush=1, perform no push and no pop in that cycle, set count and both pointers to 0 at the edge, and show out_valid=0 from the next cycle.
REQ-025 SHALL leave in_ready=0 whenever count==DEPTH, including in a cycle where out_ready=1.

Reset
REQ-026 SHALL, while reset=1 at a rising edge, clear count, the read pointer and the write pointer to 0.
REQ-027 SHALL give reset priority over flush, push and pop; reset mid-transfer discards every held entry.
REQ-028 SHALL present out_valid=0, in_ready=1 and count=0 in the first cycle after reset deasserts (PASS=1: out_valid follows in_valid).
REQ-029 SHALL NOT reset the storage array.

Structure
REQ-030 SHALL place the stage payload struct typedefs (IF/ID, ID/EX, EX/MEM, MEM/WB bundles: pc, inst, imm, dnpc, sdata, alu fields, rd_addr, csr fields, funct3, control bits) in package ysyx_24080006_pkg, so WIDTH = $bits(payload type) at instantiation.
REQ-031 SHALL implement storage and pointer logic inline with no sub-module; pointer increment-with-wrap SHALL be a local function.
REQ-032 SHALL carry an elaboration-time assertion rejecting DEPTH outside 1..16.

Verification
REQ-033 SHALL cover fill to full: DEPTH=2, PASS=0, out_ready=0, push 0xA, 0xB -> count=2, in_ready=0; then out_ready=1 -> pops 0xA then 0xB.
REQ-034 SHALL cover streaming: DEPTH=2, 100 back-to-back pushes of 0..99, out_ready=1 -> 100 pops in order, after 1-cycle initial latency, with no bubble.
REQ-035 SHALL cover wrap: DEPTH=3, 10 pushes with random out_ready stalls -> values 0..9 out in order, count never exceeds 3.
REQ-036 SHALL cover flush: count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0; the flushed-cycle payload is never seen.
REQ-037 SHALL cover bypass: PASS=1, DEPTH=1, empty, in_valid=1, in_data=0x55, out_ready=1 -> out_valid=1 and out_data=0x55 in the same cycle, count stays 0.
REQ-038 SHALL cover reset mid-operation: count=2, reset=1 for 1 cycle -> count=0, out_valid=0, in_ready=1 in the following cycle.
